// File: rtl/div_unit_pkg.sv
// Shared constants and state encoding for the multi-cycle DIV/DIVU unit.
package div_unit_pkg;

  localparam int unsigned DIV_DATA_W = 32;

  localparam logic RST_ENABLE          = 1'b1;
  localparam logic DIV_RESULT_READY    = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START           = 1'b1;
  localparam logic DIV_STOP            = 1'b0;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider, one quotient bit per cycle; result held in
// DIV_END until EX drops start_i.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  busy_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*DATA_W:0]     dividend_q, dividend_d;
  logic [DATA_W-1:0]     divisor_q, divisor_d;
  logic                  sign_a_q, sign_a_d;
  logic                  sign_b_q, sign_b_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;

  logic [DATA_W:0]       diff;
  logic [DATA_W-1:0]     abs_a, abs_b;
  logic [DATA_W-1:0]     quot_fix, rem_fix;
  logic                  start_req;

  assign start_req = (start_i == DIV_START) && !annul_i;
  assign diff      = {1'b0, dividend_q[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};
  assign abs_a     = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign abs_b     = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
  assign quot_fix  = (sign_a_q ^ sign_b_q) ? -dividend_q[DATA_W-1:0]
                                           : dividend_q[DATA_W-1:0];
  assign rem_fix   = sign_a_q ? -dividend_q[2*DATA_W:DATA_W+1]
                              : dividend_q[2*DATA_W:DATA_W+1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    result_d   = result_q;
    ready_d    = ready_q;

    unique case (state_q)
      DIV_FREE: begin
        if (start_req) begin
          if (opdata2_i == '0) begin
            state_d = DIV_BYZERO;
          end else begin
            state_d    = DIV_ON;
            cnt_d      = '0;
            dividend_d = {{DATA_W{1'b0}}, abs_a, 1'b0};
            divisor_d  = abs_b;
            sign_a_d   = signed_div_i && opdata1_i[DATA_W-1];
            sign_b_d   = signed_div_i && opdata2_i[DATA_W-1];
          end
        end
      end

      // Ready is raised one cycle after entering DIV_END on this path,
      // giving the two-edge divide-by-zero latency.
      DIV_BYZERO: begin
        if (annul_i) begin
          state_d = DIV_FREE;
        end else begin
          state_d  = DIV_END;
          result_d = '0;
        end
      end

      DIV_ON: begin
        if (annul_i) begin
          state_d = DIV_FREE;
          ready_d = DIV_RESULT_NOT_READY;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = DIV_END;
          result_d = {rem_fix, quot_fix};
          ready_d  = DIV_RESULT_READY;
        end else begin
          if (diff[DATA_W]) begin
            dividend_d = {dividend_q[2*DATA_W-1:0], 1'b0};
          end else begin
            dividend_d = {diff[DATA_W-1:0], dividend_q[DATA_W-1:0], 1'b1};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DIV_END: begin
        ready_d = DIV_RESULT_READY;
        if (start_i == DIV_STOP) begin
          state_d  = DIV_FREE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = '0;
        end
      end

      default: state_d = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      result_q   <= '0;
      ready_q    <= DIV_RESULT_NOT_READY;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q != DIV_FREE) || start_req;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed fix-up, divide-by-zero,
// annul, mid-operation reset and back-to-back operations.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int unsigned n_asserts = 0;
  int unsigned n_fail    = 0;

  div_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a division, hold start until ready, verify latency, busy span,
  // result hold, then drop start and verify the return to idle.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res,
                         input int unsigned exp_lat);
    int unsigned k;
    int unsigned busy_cnt;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    k            = 0;
    busy_cnt     = 0;
    tick();
    opdata1_i = 32'hDEAD_BEEF;
    opdata2_i = 32'h0000_0003;
    signed_div_i = ~sgn;
    while (!ready_o && k < 60) begin
      if (busy_o) busy_cnt++;
      tick();
      k++;
    end
    chk({tag, " latency"}, 64'(k), 64'(exp_lat));
    chk({tag, " busy"}, 64'(busy_cnt), 64'(exp_lat));
    chk({tag, " result"}, result_o, exp_res);
    tick();
    chk({tag, " hold ready"}, 64'(ready_o), 64'd1);
    chk({tag, " hold result"}, result_o, exp_res);
    start_i = 1'b0;
    tick();
    chk({tag, " drop ready"}, 64'(ready_o), 64'd0);
    chk({tag, " drop result"}, result_o, 64'd0);
    chk({tag, " drop busy"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    tick();
    tick();
    chk("reset ready", 64'(ready_o), 64'd0);
    chk("reset result", result_o, 64'd0);
    chk("reset busy", 64'(busy_o), 64'd0);
    rst = 1'b0;
    tick();

    run_div("divu 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    run_div("div -100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33);
    run_div("div 100/-7", 1'b1, 32'd100, 32'hFFFF_FFF9, {32'h0000_0002, 32'hFFFF_FFF2}, 33);
    run_div("divu 7/100", 1'b0, 32'd7, 32'd100, {32'd7, 32'd0}, 33);
    run_div("divu big/16", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 33);
    run_div("div by zero", 1'b1, 32'd1234, 32'd0, 64'd0, 2);

    // Annul partway through the iterations.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    annul_i = 1'b1;
    tick();
    chk("annul ready", 64'(ready_o), 64'd0);
    chk("annul busy", 64'(busy_o), 64'd0);
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();
    chk("annul idle", 64'(busy_o), 64'd0);
    begin
      int unsigned seen = 0;
      for (int i = 0; i < 40; i++) begin
        if (ready_o) seen++;
        tick();
      end
      chk("annul no ready", 64'(seen), 64'd0);
    end
    run_div("divu ffffffff/1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33);

    // Annul blocks a start in DIV_FREE.
    opdata1_i = 32'd50;
    opdata2_i = 32'd5;
    start_i   = 1'b1;
    annul_i   = 1'b1;
    tick();
    chk("annul blocks start", 64'(busy_o), 64'd0);
    start_i = 1'b0;
    annul_i = 1'b0;
    tick();

    // Reset in the middle of the iterations.
    signed_div_i = 1'b1;
    opdata1_i    = 32'd999;
    opdata2_i    = 32'd4;
    start_i      = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    tick();
    chk("mid rst ready", 64'(ready_o), 64'd0);
    chk("mid rst result", result_o, 64'd0);
    rst     = 1'b0;
    start_i = 1'b0;
    tick();
    chk("mid rst idle", 64'(busy_o), 64'd0);
    run_div("div 999/4 after rst", 1'b1, 32'd999, 32'd4, {32'd3, 32'd249}, 33);

    run_div("div overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
    run_div("b2b first", 1'b0, 32'd12345, 32'd100, {32'd45, 32'd123}, 33);
    run_div("b2b second", 1'b1, 32'hFFFF_FF00, 32'hFFFF_FFF0, {32'd0, 32'd16}, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
